// File: rtl/serial_compare_driver.sv
// Serial WIDTH-bit unsigned magnitude comparator, one 4-bit slice per clock.
// Ports: clk, rst_n, iStart, iData_a, iData_b, iCasc -> oBusy, oDone, oData.
module serial_compare_driver #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iCasc,
  output logic             oBusy,
  output logic             oDone,
  output logic [2:0]       oData
);

  localparam int SLICES = WIDTH / 4;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       res_q;
  logic [2:0]       data_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0]       sa;
  logic [3:0]       sb;
  logic [2:0]       res_d;
  logic             last;

  always_comb begin
    sa    = a_q[{idx_q, 2'b00} +: 4];
    sb    = b_q[{idx_q, 2'b00} +: 4];
    last  = (idx_q == IW'(SLICES - 1));
    res_d = res_q;
    if (sa > sb) begin
      res_d = 3'b100;
    end else if (sa < sb) begin
      res_d = 3'b010;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iStart) begin
            a_q     <= iData_a;
            b_q     <= iData_b;
            res_q   <= iCasc;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q <= res_d;
          idx_q <= idx_q + IW'(1);
          if (last) begin
            idx_q   <= '0;
            data_q  <= res_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oData = data_q;

endmodule
